// File: rtl/decoder.sv
// Decodes PCIe TLP header byte 0 (Fmt/Type) into a one-hot type code and keeps saturating hit/error counters.
// Latency: one clock from a sampled byte to data_out/out_valid/unsupported; counters update on that same edge.
// Backpressure: none; a byte is accepted on every edge where in_valid is high.
module decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    input  logic        in_valid,
    output logic [9:0]  data_out,
    output logic        out_valid,
    output logic        unsupported,
    output logic [15:0] tlp_count,
    output logic [7:0]  err_count
);

    logic [9:0] dec_dat;
    logic       dec_hit;

    // Exact 8-bit match: Fmt bits must agree too, so e.g. a 4DW MRd (0x20) is rejected.
    always_comb begin
        dec_dat = '0;
        case (data_in)
            8'h00:   dec_dat = 10'h001;
            8'h01:   dec_dat = 10'h002;
            8'h02:   dec_dat = 10'h004;
            8'h42:   dec_dat = 10'h008;
            8'h04:   dec_dat = 10'h010;
            8'h44:   dec_dat = 10'h020;
            8'h05:   dec_dat = 10'h040;
            8'h45:   dec_dat = 10'h080;
            8'h0A:   dec_dat = 10'h100;
            8'h4A:   dec_dat = 10'h200;
            default: dec_dat = '0;
        endcase
    end

    assign dec_hit = |dec_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out    <= '0;
            out_valid   <= 1'b0;
            unsupported <= 1'b0;
            tlp_count   <= '0;
            err_count   <= '0;
        end else begin
            data_out    <= in_valid ? dec_dat : '0;
            out_valid   <= in_valid;
            unsupported <= in_valid & ~dec_hit;
            if (in_valid && dec_hit && tlp_count != 16'hFFFF)
                tlp_count <= tlp_count + 16'd1;
            if (in_valid && !dec_hit && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Directed and randomized checks of the TLP type decoder against a table-driven reference model.
module tb_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        in_valid;
    logic [9:0]  data_out;
    logic        out_valid;
    logic        unsupported;
    logic [15:0] tlp_count;
    logic [7:0]  err_count;

    decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .unsupported (unsupported),
        .tlp_count   (tlp_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // Reference: position in this table is the one-hot bit index.
    logic [7:0] codes [10] = '{8'h00, 8'h01, 8'h02, 8'h42, 8'h04,
                               8'h44, 8'h05, 8'h45, 8'h0A, 8'h4A};

    int checks   = 0;
    int pass_cnt = 0;
    int exp_tlp  = 0;
    int exp_err  = 0;
    logic [9:0] exp_out;
    logic       exp_vld;
    logic       exp_uns;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, " data_out"},    32'(data_out),    32'(exp_out));
        check({tag, " out_valid"},   32'(out_valid),   32'(exp_vld));
        check({tag, " unsupported"}, 32'(unsupported), 32'(exp_uns));
        check({tag, " tlp_count"},   32'(tlp_count),   exp_tlp);
        check({tag, " err_count"},   32'(err_count),   exp_err);
    endtask

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 10; i++)
            if (codes[i] == b) return i;
        return -1;
    endfunction

    // Apply one byte for one edge, update the model, then check everything 1ns after the edge.
    task automatic step(input logic [7:0] d, input logic v, input string tag);
        int idx;
        data_in  = d;
        in_valid = v;
        @(posedge clk);
        #1;
        idx     = lookup(d);
        exp_vld = v;
        exp_uns = v && (idx < 0);
        exp_out = (v && idx >= 0) ? 10'(1 << idx) : 10'h000;
        if (v && idx >= 0 && exp_tlp < 65535) exp_tlp = exp_tlp + 1;
        if (v && idx < 0 && exp_err < 255)    exp_err = exp_err + 1;
        check_all(tag);
        check({tag, " onehot0"}, 32'($onehot0(data_out)), 32'd1);
    endtask

    task automatic model_reset();
        exp_out = '0;
        exp_vld = 1'b0;
        exp_uns = 1'b0;
        exp_tlp = 0;
        exp_err = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        data_in  = 8'h00;
        in_valid = 1'b1;
        model_reset();
        #2;
        check_all("reset_pre_edge");
        @(posedge clk);
        #1;
        check_all("reset_held_edge");
        #2;
        rst_n = 1'b1;

        // Full sweep of every supported type, back to back.
        for (int i = 0; i < 10; i++)
            step(codes[i], 1'b1, "sweep");
        check("sweep_total", 32'(tlp_count), 32'd10);

        step(8'h06, 1'b1, "unsup_06");
        check("unsup_err1", 32'(err_count), 32'd1);
        step(8'h42, 1'b0, "idle_42");
        step(8'h40, 1'b1, "unsup_40");
        step(8'h20, 1'b1, "unsup_20");
        step(8'h4A, 1'b1, "cpld");
        step(8'hFF, 1'b1, "unsup_ff");

        // Asynchronous reset between edges after traffic.
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        data_in  = 8'h0A;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset_during_edge");
        #2;
        rst_n = 1'b1;
        step(8'h0A, 1'b1, "first_after_reset");
        check("first_after_reset_cpl", 32'(data_out), 32'h100);

        // Error counter saturation.
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++)
            step(8'hFF, 1'b1, "sat");
        check("sat_err", 32'(err_count), 32'd255);
        check("sat_tlp", 32'(tlp_count), 32'd0);
        step(8'h00, 1'b1, "sat_then_mrd");

        // Random traffic, biased so supported codes appear often.
        for (int i = 0; i < 10000; i++) begin
            logic [7:0] b;
            if ($urandom_range(1, 0) == 1) b = codes[$urandom_range(9, 0)];
            else                           b = 8'($urandom);
            step(b, 1'($urandom_range(3, 0) != 0), "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, checks);
        $finish;
    end

endmodule
